// File: rtl/masked_keyadd_pkg.sv
// Shared definitions for the masked key-addition front-end: host order codes,
// controller state encoding and default parameter values.
// No ports; imported by masked_keyadd_engine and share_split.
package masked_keyadd_pkg;

  // Host order codes (2-bit command bus)
  localparam logic [1:0] ORD_KEY   = 2'b00;
  localparam logic [1:0] ORD_DATA  = 2'b01;
  localparam logic [1:0] ORD_RUN   = 2'b10;
  localparam logic [1:0] ORD_ABORT = 2'b11;

  // Default configuration
  localparam int DEF_WIDTH   = 128;
  localparam int DEF_NSHARES = 3;
  localparam int DEF_NROUNDS = 12;
  localparam int DEF_ROT     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/share_split.sv
// Combinational Boolean masking of one WIDTH-bit word into NSHARES shares.
// Ports: data_i (plain word), rnd_i (NSHARES-1 random words, part k in bits
// [k*WIDTH +: WIDTH]), shares_o (share 0 = data ^ all parts, share i = part i-1).
module share_split #(
  parameter int WIDTH   = 128,
  parameter int NSHARES = 3
) (
  input  logic [WIDTH-1:0]               data_i,
  input  logic [(NSHARES-1)*WIDTH-1:0]   rnd_i,
  output logic [NSHARES-1:0][WIDTH-1:0]  shares_o
);

  logic [WIDTH-1:0] acc;

  always_comb begin
    shares_o = '0;
    acc      = data_i;
    for (int i = 1; i < NSHARES; i++) begin
      shares_o[i] = rnd_i[(i-1)*WIDTH +: WIDTH];
      acc         = acc ^ rnd_i[(i-1)*WIDTH +: WIDTH];
    end
    shares_o[0] = acc;
  end

endmodule

// File: rtl/masked_keyadd_engine.sv
// Masked key-addition engine: key and data held as NSHARES Boolean shares,
// NROUNDS rounds of share-wise key addition with per-round key rotation, then
// recombination into data_out with a one-cycle done pulse.
// Ports: clk, reset (sync, active-low), order (00 key/01 data/10 run/11 abort),
// data_in, rnd (fresh randomness), data_out, busy, done, key_valid.
// Build option: define MASK_REFRESH_EN to re-randomise data shares every round;
// without it rnd is only consumed at loads (recombined result is identical).
module masked_keyadd_engine
  import masked_keyadd_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NSHARES = DEF_NSHARES,
  parameter int NROUNDS = DEF_NROUNDS,
  parameter int ROT     = DEF_ROT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     order,
  input  logic [WIDTH-1:0]               data_in,
  input  logic [(NSHARES-1)*WIDTH-1:0]   rnd,
  output logic [WIDTH-1:0]               data_out,
  output logic                           busy,
  output logic                           done,
  output logic                           key_valid
);

  localparam int CW = $clog2(NROUNDS + 1);
  localparam int RS = ROT % WIDTH;
  localparam logic [CW-1:0] LAST_RND = CW'(NROUNDS - 1);

  typedef logic [NSHARES-1:0][WIDTH-1:0] shares_t;

  state_e           state_q, state_d;
  shares_t          key_sh_q, key_sh_d;   // key store, untouched by runs
  shares_t          wk_q, wk_d;           // working (rotating) key shares
  shares_t          dat_sh_q, dat_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             done_q, done_d;
  logic             key_valid_q, key_valid_d;
  logic             data_valid_q, data_valid_d;

  shares_t          split_sh;
  shares_t          rf;                   // per-round refresh masks
  logic [WIDTH-1:0] recomb;

  // One splitter serves both key and data loads: only one load per cycle.
  share_split #(
    .WIDTH   (WIDTH),
    .NSHARES (NSHARES)
  ) u_split (
    .data_i   (data_in),
    .rnd_i    (rnd),
    .shares_o (split_sh)
  );

  // Rotate through a doubled word so ROT==0 needs no special case.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
    logic [2*WIDTH-1:0] t;
    t = {x, x} << RS;
    return t[2*WIDTH-1 -: WIDTH];
  endfunction

  // Refresh masks XOR to zero across shares, so the secret is unchanged.
  always_comb begin
    rf = '0;
`ifdef MASK_REFRESH_EN
    for (int i = 1; i < NSHARES; i++) begin
      rf[i] = rnd[(i-1)*WIDTH +: WIDTH];
      rf[0] = rf[0] ^ rnd[(i-1)*WIDTH +: WIDTH];
    end
`endif
  end

  always_comb begin
    recomb = '0;
    for (int i = 0; i < NSHARES; i++) recomb = recomb ^ dat_sh_q[i];
  end

  always_comb begin
    state_d      = state_q;
    key_sh_d     = key_sh_q;
    wk_d         = wk_q;
    dat_sh_d     = dat_sh_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    done_d       = 1'b0;
    key_valid_d  = key_valid_q;
    data_valid_d = data_valid_q;

    case (state_q)
      IDLE: begin
        case (order)
          ORD_KEY: begin
            key_sh_d    = split_sh;
            key_valid_d = 1'b1;
          end
          ORD_DATA: begin
            dat_sh_d     = split_sh;
            data_valid_d = 1'b1;
          end
          ORD_RUN: begin
            if (key_valid_q && data_valid_q) begin
              wk_d    = key_sh_q;
              cnt_d   = '0;
              state_d = RUN;
            end
          end
          default: ;
        endcase
      end
      RUN: begin
        if (order == ORD_ABORT) begin
          dat_sh_d     = '0;
          wk_d         = '0;
          data_valid_d = 1'b0;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          for (int i = 0; i < NSHARES; i++) begin
            dat_sh_d[i] = dat_sh_q[i] ^ wk_q[i] ^ rf[i];
            wk_d[i]     = rotl(wk_q[i]);
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_RND) state_d = DONE;
        end
      end
      DONE: begin
        data_out_d   = recomb;
        done_d       = 1'b1;
        data_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      key_sh_q     <= '0;
      wk_q         <= '0;
      dat_sh_q     <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      done_q       <= 1'b0;
      key_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_sh_q     <= key_sh_d;
      wk_q         <= wk_d;
      dat_sh_q     <= dat_sh_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      done_q       <= done_d;
      key_valid_q  <= key_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign data_out  = data_out_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_masked_keyadd_engine.sv
// Self-checking bench for masked_keyadd_engine (default configuration).
// Directed sequence with random keys/data/randomness against a plain model.
// Outputs sampled 1 time unit after each rising edge.
module tb_masked_keyadd_engine;

  localparam int W  = 128;
  localparam int NS = 3;
  localparam int NR = 12;
  localparam int RT = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            order;
  logic [W-1:0]          data_in;
  logic [(NS-1)*W-1:0]   rnd;
  logic [W-1:0]          data_out;
  logic                  busy, done, key_valid;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  logic [W-1:0] key_m, dout_m;

  masked_keyadd_engine #(
    .WIDTH   (W),
    .NSHARES (NS),
    .NROUNDS (NR),
    .ROT     (RT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .order     (order),
    .data_in   (data_in),
    .rnd       (rnd),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Result = data XOR (XOR over rounds of key rotated left by r*ROT bits)
  function automatic logic [W-1:0] model(input logic [W-1:0] k, input logic [W-1:0] d);
    logic [W-1:0] acc;
    int s;
    acc = d;
    for (int r = 0; r < NR; r++) begin
      s = (r * RT) % W;
      if (s == 0) acc = acc ^ k;
      else        acc = acc ^ ((k << s) | (k >> (W - s)));
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] o, input logic [W-1:0] d);
    @(negedge clk);
    order   = o;
    data_in = d;
    for (int i = 0; i < (NS-1)*W/32; i++) rnd[i*32 +: 32] = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [W-1:0] k);
    cyc(2'b00, k);
    key_m = k;
    chk("key_valid_after_load", W'(key_valid), W'(1));
  endtask

  // Issue run and follow it to completion; 10 is ignored in RUN and DONE.
  task automatic run_chk(input string tag, input logic [W-1:0] expd);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = -1;
    cyc(2'b10, '0);
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = k;
        break;
      end
      cyc(2'b10, '0);
    end
    chk({tag, "_done_latency"}, W'(done_at), W'(NR + 1));
    chk({tag, "_busy_cycles"}, W'(busy_n), W'(NR));
    chk({tag, "_data_out"}, data_out, expd);
    dout_m = expd;
    cyc(2'b11, '0);
    chk({tag, "_done_pulse_end"}, W'(done), W'(0));
    chk({tag, "_data_out_hold"}, data_out, dout_m);
  endtask

  // A run that must be refused: no busy, no done, data_out unchanged.
  task automatic ign_chk(input string tag);
    logic seen;
    seen = 1'b0;
    cyc(2'b10, '0);
    for (int k = 0; k < 4; k++) begin
      if (busy || done) seen = 1'b1;
      cyc(2'b11, '0);
    end
    chk({tag, "_no_activity"}, W'(seen), W'(0));
    chk({tag, "_data_out"}, data_out, dout_m);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] k;
    logic         seen;

    reset   = 1'b0;
    order   = 2'b11;
    data_in = '0;
    rnd     = '0;
    key_m   = '0;
    dout_m  = '0;
    cyc(2'b11, '0);
    cyc(2'b11, '0);
    chk("rst_data_out", data_out, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_key_valid", W'(key_valid), W'(0));
    reset = 1'b1;

    // Run with nothing loaded
    ign_chk("run_no_key");

    // Key 0: data passes through unchanged
    load_key('0);
    d = {1'b1, 127'b0};
    cyc(2'b01, d);
    run_chk("key0", d);

    // Completed run, no data reload: refused
    ign_chk("run_no_data");
    chk("key_valid_persists", W'(key_valid), W'(1));

    // Byte-repeating key is rotation invariant; 12 rounds cancel out
    load_key({16{8'h01}});
    cyc(2'b01, {16{8'h01}});
    run_chk("rep01", {16{8'h01}});

    // Key 1: bytes 0..11 each pick up a 01
    load_key(128'h1);
    cyc(2'b01, '0);
    run_chk("key1", 128'h00000000_01010101_01010101_01010101);

    // Random keys and data against the model
    for (int n = 0; n < 3; n++) begin
      k = rnd128();
      d = rnd128();
      load_key(k);
      cyc(2'b01, d);
      run_chk($sformatf("rand%0d", n), model(k, d));
    end

    // Abort at round 5
    d = rnd128();
    cyc(2'b01, d);
    cyc(2'b10, '0);
    for (int i = 0; i < 5; i++) cyc(2'b10, '0);
    cyc(2'b11, '0);
    chk("abort_busy_drop", W'(busy), W'(0));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) seen = 1'b1;
      cyc(2'b11, '0);
    end
    chk("abort_no_done", W'(seen), W'(0));
    chk("abort_data_out", data_out, dout_m);
    ign_chk("run_after_abort");
    d = rnd128();
    cyc(2'b01, d);
    run_chk("after_abort", model(key_m, d));

    // Reset at round 3
    d = rnd128();
    cyc(2'b01, d);
    cyc(2'b10, '0);
    for (int i = 0; i < 3; i++) cyc(2'b10, '0);
    reset = 1'b0;
    cyc(2'b10, '0);
    reset = 1'b1;
    dout_m = '0;
    chk("midrst_data_out", data_out, '0);
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    chk("midrst_key_valid", W'(key_valid), W'(0));
    cyc(2'b01, rnd128());
    ign_chk("run_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/masked_keyadd_engine.md
Name: masked_keyadd_engine

Overview:
- Parametrised successor to the Anubis_2 masked core front-end.
- Holds key and data as NSHARES Boolean shares. Runs NROUNDS masked key-addition rounds with per-round key rotation and share refresh, then recombines the result.
- Sits between the order-driven host interface and the future masked Anubis round datapath. Uses the same 2-bit order command scheme and external randomness.

Parameters:
- WIDTH, 128, block and key width in bits (multiple of 8).
- NSHARES, 3, number of Boolean shares (>=2).
- NROUNDS, 12, rounds per run (>=1).
- ROT, 8, left-rotation of each key share per round, in bits (0..WIDTH-1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- order  in  2  command: 00 load key, 01 load data, 10 run, 11 abort.
- data_in  in  WIDTH  key or plaintext for load commands.
- rnd  in  (NSHARES-1)*WIDTH  fresh randomness, sampled every cycle it is used.
- data_out  out  WIDTH  recombined result, valid when done is high.
- busy  out  1  high during rounds.
- done  out  1  one-cycle pulse when data_out is updated.
- key_valid  out  1  key shares loaded.

Behaviour:
- Reset (reset==0 at an edge): all shares, key store, round counter, data_out, busy, done, key_valid and data_valid go to 0. State goes to IDLE. Reset mid-run discards the run; no done.
- Split rule (loads): share i = rnd[i-1] for i=1..NSHARES-1; share 0 = data_in XOR all rnd parts.
- IDLE, order 00: key store shares loaded by the split rule; key_valid=1 next cycle.
- IDLE, order 01: data shares loaded by the split rule; data_valid=1.
- IDLE, order 10 with key_valid&&data_valid: working key shares copied from key store; round counter=0; state RUN; busy=1 from the next cycle.
- IDLE, order 10 with either flag low: ignored, no state change.
- IDLE, order 11: no effect.
- RUN, each cycle r=0..NROUNDS-1:
  - data share i ^= working key share i.
  - working key share i = rotl(key share i, ROT).
  - Refresh: data share 0 ^= XOR of all rnd parts; data share i ^= rnd[i-1].
- RUN exit: after the cycle with r==NROUNDS-1, state goes to DONE.
- DONE (one cycle): data_out <= XOR of data shares; done=1 for exactly this cycle; busy=0; data_valid cleared; state goes to IDLE.
- Latency: order 10 sampled at edge t; busy high for edges t+1..t+NROUNDS; done and data_out valid after edge t+NROUNDS+1.
- Result: data_out = data XOR (XOR over r=0..NROUNDS-1 of rotl(key, r*ROT)).
- data_out holds its value until the next DONE or reset.
- key_valid persists across runs; the key store is never modified by a run.
- RUN, order 00/01/10: ignored.
- RUN, order 11: abort. Data shares and working key zeroed; data_valid=0; state goes to IDLE next cycle; no done; data_out unchanged.
- ROT==0: key constant per round.
- Rotation wraps modulo WIDTH.
- Round counter is $clog2(NROUNDS+1) bits. It resets to 0 on run start and abort.

Optional Feature:
- Macro MASK_REFRESH_EN.
- Defined: per-round refresh as above; rnd is consumed every RUN cycle.
- Undefined: no refresh in RUN; rnd is used only at loads. Share values differ from the defined case; data_out is identical. Saves NSHARES*WIDTH XOR gates.

Decomposition:
- Package masked_keyadd_pkg:
  - order code constants ORD_KEY=2'b00, ORD_DATA=2'b01, ORD_RUN=2'b10, ORD_ABORT=2'b11.
  - state enum IDLE/RUN/DONE.
  - default parameter constants.
- Sub-module share_split, combinational: data_in + rnd -> NSHARES shares. Instantiated twice (key, data), or once, muxed.
- XOR recombination and rotation stay inline.

Test Plan:
- Key 0, data 128'h8000...0, run -> done after NROUNDS+1 cycles; data_out=128'h8000...0; busy high exactly 12 cycles.
- Key 128'h0101...01 (rotation-invariant, even NROUNDS=12), data 128'h0101...01 -> data_out=128'h0101...01.
- Key 128'h1, data 0, ROT=8, NROUNDS=12 -> data_out=128'h00000000_01010101_01010101_01010101.
- Run before any key load, or after a completed run without a data reload -> no busy, no done; data_out unchanged.
- Abort with order 11 at round 5 -> busy drops next cycle, no done; a following data load + run gives the correct result.
- Reset=0 at round 3 -> all outputs 0 next cycle; key_valid=0; a run without reloading the key is ignored.
